// File: rtl/chattering_debouncer_pkg.sv
// Shared constants and helpers for the multi-channel switch debouncer.
// Imported by the debounce cell and the top level.
package chattering_debouncer_pkg;

    localparam int PRESCALE_DE0     = 50000;
    localparam int STABLE_TICKS_DEF = 4;

    // Bits needed to hold 0..v-1, never less than one bit.
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'(1) << i) < v) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/chattering_debouncer_cell.sv
// One debounced channel: two-flop synchronizer, stability counter,
// accepted-level flop and registered rise/fall pulses.
module debounce_cell
    import chattering_debouncer_pkg::*;
#(
    parameter int STABLE_TICKS = STABLE_TICKS_DEF,
    parameter bit RST_LEVEL    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int              SW       = clog2_min1(STABLE_TICKS);
    localparam logic [SW-1:0]   STAB_MAX = SW'(STABLE_TICKS - 1);

    logic [1:0]    sync_q;
    logic [SW-1:0] stab_q;
    logic          sync;
    logic          differ;
    logic          accept;

    assign sync   = sync_q[1];
    assign differ = (sync != db);
    assign accept = tick && differ && (stab_q == STAB_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{RST_LEVEL}};
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    // A level that flips back before acceptance loses all accumulated credit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_q <= '0;
        end else if (tick) begin
            if (!differ || accept) begin
                stab_q <= '0;
            end else begin
                stab_q <= stab_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db <= RST_LEVEL;
        end else if (accept) begin
            db <= sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= accept && sync;
            fall <= accept && !sync;
        end
    end

endmodule

// File: rtl/chattering_debouncer.sv
// Multi-channel switch debouncer with a shared sample-tick prescaler
// and an event counter driven by channel rise pulses.
module chattering_debouncer
    import chattering_debouncer_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter int PRESCALE     = PRESCALE_DE0,
    parameter int STABLE_TICKS = STABLE_TICKS_DEF,
    parameter int CNT_W        = 9,
    parameter int SATURATE     = 0,
    parameter bit RST_LEVEL    = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] switch,
    output logic [CHANNELS-1:0] sw_db,
    output logic [CHANNELS-1:0] sw_rise,
    output logic [CHANNELS-1:0] sw_fall,
    output logic                tick,
    output logic [CNT_W-1:0]    led
);

    localparam int            PW   = clog2_min1(PRESCALE);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic          inc;
    logic          clr;

    // Tick is registered, so it is high while the count has wrapped to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= (pre_q == PMAX);
            if (pre_q == PMAX) begin
                pre_q <= '0;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_cell #(
            .STABLE_TICKS(STABLE_TICKS),
            .RST_LEVEL   (RST_LEVEL)
        ) u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick),
            .raw  (switch[i]),
            .db   (sw_db[i]),
            .rise (sw_rise[i]),
            .fall (sw_fall[i])
        );
    end

    assign inc = sw_rise[0];

    if (CHANNELS >= 2) begin : g_clr
        assign clr = sw_rise[1];
    end else begin : g_no_clr
        assign clr = 1'b0;
    end

    // Clear outranks increment when both pulses land together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= '0;
        end else if (clr) begin
            led <= '0;
        end else if (inc) begin
            if (led == '1) begin
                led <= (SATURATE != 0) ? led : '0;
            end else begin
                led <= led + 1'b1;
            end
        end
    end

endmodule
